// File: rtl/punc_controller_pkg.sv
// Shared constants and types for the PUnC LC3 control unit: opcodes, FSM
// states, datapath mux selects, ALU functions, SEXT codes and the control bundle.
package punc_controller_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_EXEC2   = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] MEM_R_PC       = 3'd0;
  localparam logic [2:0] MEM_R_PC_ADDER = 3'd1;
  localparam logic [2:0] MEM_R_INDIRECT = 3'd2;
  localparam logic [2:0] MEM_R_DATA     = 3'd3;
  localparam logic [2:0] MEM_R_ALU      = 3'd4;

  localparam logic [1:0] RF_W_ALU      = 2'd0;
  localparam logic [1:0] RF_W_PC       = 2'd1;
  localparam logic [1:0] RF_W_MEM      = 2'd2;
  localparam logic [1:0] RF_W_PC_ADDER = 2'd3;

  localparam logic [1:0] ALU_FN_PASS = 2'd0;
  localparam logic [1:0] ALU_FN_ADD  = 2'd1;
  localparam logic [1:0] ALU_FN_AND  = 2'd2;
  localparam logic [1:0] ALU_FN_NOT  = 2'd3;

  localparam logic [3:0] SEXT_IMM5  = 4'b1000;
  localparam logic [3:0] SEXT_OFF6  = 4'b0100;
  localparam logic [3:0] SEXT_OFF9  = 4'b0010;
  localparam logic [3:0] SEXT_OFF11 = 4'b0001;

  localparam logic [2:0] REG_LINK = 3'd7;

  // One bundle of every datapath control; const_val carries the ir[10:0] constant.
  typedef struct packed {
    logic        mem_wr_en;
    logic [2:0]  mem_r_addr_sel;
    logic        state2_STI;
    logic        STR;
    logic [2:0]  RF_wr_addr;
    logic        RF_wr_en;
    logic [2:0]  RF_r_addr_0;
    logic [2:0]  RF_r_addr_1;
    logic [1:0]  RF_w_data_sel;
    logic        ir_ld;
    logic        JMP_RET_JSRR;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu_sel;
    logic        cc_en;
    logic        n;
    logic        z;
    logic        p;
    logic [10:0] const_val;
    logic [3:0]  SEXT_Select;
  } ctrl_t;

endpackage

// File: rtl/punc_controller_if.sv
// Controller-to-datapath bundle: the datapath returns ir, the controller
// drives every control input. "const" is a reserved word, hence const_val.
interface punc_controller_if;

  logic [15:0] ir;
  logic        mem_wr_en;
  logic [2:0]  mem_r_addr_sel;
  logic        state2_STI;
  logic        STR;
  logic [2:0]  RF_wr_addr;
  logic        RF_wr_en;
  logic [2:0]  RF_r_addr_0;
  logic [2:0]  RF_r_addr_1;
  logic [1:0]  RF_w_data_sel;
  logic        ir_ld;
  logic        JMP_RET_JSRR;
  logic        pc_ld;
  logic        pc_clr;
  logic        pc_up;
  logic        add_const;
  logic [1:0]  alu_sel;
  logic        cc_en;
  logic        n;
  logic        z;
  logic        p;
  logic [10:0] const_val;
  logic [3:0]  SEXT_Select;

  modport master (
    input  ir,
    output mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
           RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR,
           pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p,
           const_val, SEXT_Select
  );

  modport slave (
    output ir,
    input  mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
           RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR,
           pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p,
           const_val, SEXT_Select
  );

endinterface

// File: rtl/punc_controller_decode.sv
// Purely combinational map from (state, ir) to every datapath control signal.
// Register writes always target DR = ir[11:9] except JSR/JSRR, which link into R7.
module punc_ctrl_decode
  import punc_controller_pkg::*;
(
  input  state_t      state,
  input  logic [15:0] ir,
  output ctrl_t       ctrl
);

  logic [3:0] opcode;
  logic [2:0] dr;
  logic [2:0] baseR;

  assign opcode = ir[15:12];
  assign dr     = ir[11:9];
  assign baseR  = ir[8:6];

  always_comb begin
    ctrl           = '0;
    ctrl.const_val = ir[10:0];
    case (state)
      ST_INIT: ctrl.pc_clr = 1'b1;
      ST_FETCH: begin
        ctrl.mem_r_addr_sel = MEM_R_PC;
        ctrl.ir_ld          = 1'b1;
        ctrl.pc_up          = 1'b1;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_ADD, OP_AND: begin
            ctrl.RF_r_addr_0 = baseR;
            if (ir[5]) begin
              ctrl.add_const   = 1'b1;
              ctrl.SEXT_Select = SEXT_IMM5;
            end else begin
              ctrl.RF_r_addr_1 = ir[2:0];
            end
            ctrl.alu_sel       = (opcode == OP_ADD) ? ALU_FN_ADD : ALU_FN_AND;
            ctrl.RF_w_data_sel = RF_W_ALU;
            ctrl.RF_wr_addr    = dr;
            ctrl.RF_wr_en      = 1'b1;
            ctrl.cc_en         = 1'b1;
          end
          OP_NOT: begin
            ctrl.RF_r_addr_0   = baseR;
            ctrl.alu_sel       = ALU_FN_NOT;
            ctrl.RF_w_data_sel = RF_W_ALU;
            ctrl.RF_wr_addr    = dr;
            ctrl.RF_wr_en      = 1'b1;
            ctrl.cc_en         = 1'b1;
          end
          OP_BR: begin
            ctrl.n           = ir[11];
            ctrl.z           = ir[10];
            ctrl.p           = ir[9];
            ctrl.SEXT_Select = SEXT_OFF9;
          end
          OP_LD: begin
            ctrl.SEXT_Select    = SEXT_OFF9;
            ctrl.mem_r_addr_sel = MEM_R_PC_ADDER;
            ctrl.RF_w_data_sel  = RF_W_MEM;
            ctrl.RF_wr_addr     = dr;
            ctrl.RF_wr_en       = 1'b1;
          end
          OP_LDI, OP_STI: begin
            ctrl.SEXT_Select    = SEXT_OFF9;
            ctrl.mem_r_addr_sel = MEM_R_PC_ADDER;
          end
          OP_ST: begin
            ctrl.SEXT_Select = SEXT_OFF9;
            ctrl.RF_r_addr_0 = dr;
            ctrl.alu_sel     = ALU_FN_PASS;
            ctrl.mem_wr_en   = 1'b1;
          end
          OP_LDR: begin
            ctrl.RF_r_addr_0    = baseR;
            ctrl.add_const      = 1'b1;
            ctrl.SEXT_Select    = SEXT_OFF6;
            ctrl.alu_sel        = ALU_FN_ADD;
            ctrl.mem_r_addr_sel = MEM_R_ALU;
            ctrl.RF_w_data_sel  = RF_W_MEM;
            ctrl.RF_wr_addr     = dr;
            ctrl.RF_wr_en       = 1'b1;
          end
          OP_STR: begin
            ctrl.RF_r_addr_0 = baseR;
            ctrl.add_const   = 1'b1;
            ctrl.SEXT_Select = SEXT_OFF6;
            ctrl.alu_sel     = ALU_FN_ADD;
            ctrl.STR         = 1'b1;
            ctrl.RF_r_addr_1 = dr;
            ctrl.mem_wr_en   = 1'b1;
          end
          OP_JSR: begin
            ctrl.SEXT_Select   = SEXT_OFF11;
            ctrl.pc_ld         = 1'b1;
            ctrl.RF_wr_addr    = REG_LINK;
            ctrl.RF_w_data_sel = RF_W_PC;
            ctrl.RF_wr_en      = 1'b1;
            if (!ir[11]) begin
              ctrl.JMP_RET_JSRR = 1'b1;
              ctrl.RF_r_addr_0  = baseR;
              ctrl.alu_sel      = ALU_FN_PASS;
            end
          end
          OP_JMP: begin
            ctrl.RF_r_addr_0  = baseR;
            ctrl.alu_sel      = ALU_FN_PASS;
            ctrl.JMP_RET_JSRR = 1'b1;
            ctrl.pc_ld        = 1'b1;
          end
          OP_LEA: begin
            ctrl.SEXT_Select   = SEXT_OFF9;
            ctrl.RF_w_data_sel = RF_W_PC_ADDER;
            ctrl.RF_wr_addr    = dr;
            ctrl.RF_wr_en      = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin
        // Second memory access of the indirect instructions, via the captured pointer.
        if (opcode == OP_LDI) begin
          ctrl.mem_r_addr_sel = MEM_R_INDIRECT;
          ctrl.RF_w_data_sel  = RF_W_MEM;
          ctrl.RF_wr_addr     = dr;
          ctrl.RF_wr_en       = 1'b1;
        end else if (opcode == OP_STI) begin
          ctrl.state2_STI  = 1'b1;
          ctrl.RF_r_addr_0 = dr;
          ctrl.alu_sel     = ALU_FN_PASS;
          ctrl.mem_wr_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/punc_controller.sv
// PUnC LC3 control unit: fetch/decode/execute state register and sequencing.
// Outputs are decoded combinationally so an asserted reset masks all strobes at once.
module punc_controller
  import punc_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  punc_controller_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl;
  logic [3:0] opcode;

  assign opcode = bus.ir[15:12];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (opcode == OP_LDI || opcode == OP_STI) state_d = ST_EXEC2;
        else if (opcode == OP_HALT)               state_d = ST_HALT;
        else                                      state_d = ST_FETCH;
      end
      ST_EXEC2:   state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  punc_ctrl_decode u_decode (
    .state (state_q),
    .ir    (bus.ir),
    .ctrl  (ctrl)
  );

  assign bus.mem_wr_en      = ctrl.mem_wr_en;
  assign bus.mem_r_addr_sel = ctrl.mem_r_addr_sel;
  assign bus.state2_STI     = ctrl.state2_STI;
  assign bus.STR            = ctrl.STR;
  assign bus.RF_wr_addr     = ctrl.RF_wr_addr;
  assign bus.RF_wr_en       = ctrl.RF_wr_en;
  assign bus.RF_r_addr_0    = ctrl.RF_r_addr_0;
  assign bus.RF_r_addr_1    = ctrl.RF_r_addr_1;
  assign bus.RF_w_data_sel  = ctrl.RF_w_data_sel;
  assign bus.ir_ld          = ctrl.ir_ld;
  assign bus.JMP_RET_JSRR   = ctrl.JMP_RET_JSRR;
  assign bus.pc_ld          = ctrl.pc_ld;
  assign bus.pc_clr         = ctrl.pc_clr;
  assign bus.pc_up          = ctrl.pc_up;
  assign bus.add_const      = ctrl.add_const;
  assign bus.alu_sel        = ctrl.alu_sel;
  assign bus.cc_en          = ctrl.cc_en;
  assign bus.n              = ctrl.n;
  assign bus.z              = ctrl.z;
  assign bus.p              = ctrl.p;
  assign bus.const_val      = ctrl.const_val;
  assign bus.SEXT_Select    = ctrl.SEXT_Select;

endmodule

// File: tb/tb_punc_controller.sv
// Scoreboard bench for punc_controller: each driven cycle queues its expected
// control word, and a negedge monitor pops and compares against the DUT outputs.
module tb_punc_controller;
  import punc_controller_pkg::*;

  typedef struct {
    string name;
    ctrl_t exp;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun = 0;
  int   failCount = 0;
  item_t expQ[$];

  punc_controller_if bus ();

  punc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t dflt(input logic [15:0] irVal);
    ctrl_t c;
    c           = '0;
    c.const_val = irVal[10:0];
    return c;
  endfunction

  function automatic ctrl_t initExp(input logic [15:0] irVal);
    ctrl_t c;
    c        = dflt(irVal);
    c.pc_clr = 1'b1;
    return c;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue its expectation.
  task automatic applyStimulus(input logic rstVal, input logic [15:0] irVal,
                               input ctrl_t exp, input string name);
    item_t it;
    @(posedge clk);
    #1;
    rst    = rstVal;
    bus.ir = irVal;
    it.name = name;
    it.exp  = exp;
    expQ.push_back(it);
  endtask

  // FETCH with the old IR, then DECODE once the datapath has latched irNew.
  task automatic fetchDecode(input logic [15:0] irNew, input string name);
    ctrl_t e;
    e       = dflt(bus.ir);
    e.ir_ld = 1'b1;
    e.pc_up = 1'b1;
    applyStimulus(1'b1, bus.ir, e, {name, "_fetch"});
    applyStimulus(1'b1, irNew, dflt(irNew), {name, "_decode"});
  endtask

  task automatic checkOutput(input item_t it);
    ctrl_t act;
    act.mem_wr_en      = bus.mem_wr_en;
    act.mem_r_addr_sel = bus.mem_r_addr_sel;
    act.state2_STI     = bus.state2_STI;
    act.STR            = bus.STR;
    act.RF_wr_addr     = bus.RF_wr_addr;
    act.RF_wr_en       = bus.RF_wr_en;
    act.RF_r_addr_0    = bus.RF_r_addr_0;
    act.RF_r_addr_1    = bus.RF_r_addr_1;
    act.RF_w_data_sel  = bus.RF_w_data_sel;
    act.ir_ld          = bus.ir_ld;
    act.JMP_RET_JSRR   = bus.JMP_RET_JSRR;
    act.pc_ld          = bus.pc_ld;
    act.pc_clr         = bus.pc_clr;
    act.pc_up          = bus.pc_up;
    act.add_const      = bus.add_const;
    act.alu_sel        = bus.alu_sel;
    act.cc_en          = bus.cc_en;
    act.n              = bus.n;
    act.z              = bus.z;
    act.p              = bus.p;
    act.const_val      = bus.const_val;
    act.SEXT_Select    = bus.SEXT_Select;
    testsRun++;
    if (act !== it.exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", it.name, act, it.exp);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput(expQ.pop_front());
  end

  initial begin
    ctrl_t e;
    bus.ir = 16'h0000;

    applyStimulus(1'b0, 16'h0000, initExp(16'h0000), "reset_init");
    applyStimulus(1'b0, 16'h0000, initExp(16'h0000), "reset_held");
    applyStimulus(1'b1, 16'h0000, initExp(16'h0000), "reset_release");

    // ADD R1,R1,#1
    fetchDecode(16'h1261, "add_imm");
    e = dflt(16'h1261);
    e.RF_r_addr_0 = 3'd1; e.add_const = 1'b1; e.SEXT_Select = 4'b1000;
    e.alu_sel = 2'd1; e.RF_wr_addr = 3'd1; e.RF_wr_en = 1'b1; e.cc_en = 1'b1;
    applyStimulus(1'b1, 16'h1261, e, "add_imm_exec");

    // AND R5,R2,R3
    fetchDecode(16'h5A83, "and_reg");
    e = dflt(16'h5A83);
    e.RF_r_addr_0 = 3'd2; e.RF_r_addr_1 = 3'd3; e.alu_sel = 2'd2;
    e.RF_wr_addr = 3'd5; e.RF_wr_en = 1'b1; e.cc_en = 1'b1;
    applyStimulus(1'b1, 16'h5A83, e, "and_reg_exec");

    // LDI R2,#2: two execute cycles
    fetchDecode(16'hA402, "ldi");
    e = dflt(16'hA402);
    e.SEXT_Select = 4'b0010; e.mem_r_addr_sel = 3'd1;
    applyStimulus(1'b1, 16'hA402, e, "ldi_exec");
    e = dflt(16'hA402);
    e.mem_r_addr_sel = 3'd2; e.RF_w_data_sel = 2'd2; e.RF_wr_addr = 3'd2; e.RF_wr_en = 1'b1;
    applyStimulus(1'b1, 16'hA402, e, "ldi_exec2");

    // BRz #2
    fetchDecode(16'h0402, "brz");
    e = dflt(16'h0402);
    e.z = 1'b1; e.SEXT_Select = 4'b0010;
    applyStimulus(1'b1, 16'h0402, e, "brz_exec");

    // JSR #2
    fetchDecode(16'h4802, "jsr");
    e = dflt(16'h4802);
    e.SEXT_Select = 4'b0001; e.pc_ld = 1'b1; e.RF_wr_addr = 3'd7;
    e.RF_w_data_sel = 2'd1; e.RF_wr_en = 1'b1;
    applyStimulus(1'b1, 16'h4802, e, "jsr_exec");

    // JSRR R7: reads R7 while linking into R7
    fetchDecode(16'h41C0, "jsrr_r7");
    e = dflt(16'h41C0);
    e.SEXT_Select = 4'b0001; e.pc_ld = 1'b1; e.JMP_RET_JSRR = 1'b1; e.RF_r_addr_0 = 3'd7;
    e.RF_wr_addr = 3'd7; e.RF_w_data_sel = 2'd1; e.RF_wr_en = 1'b1;
    applyStimulus(1'b1, 16'h41C0, e, "jsrr_r7_exec");

    // STI R3,#5
    fetchDecode(16'hB605, "sti");
    e = dflt(16'hB605);
    e.SEXT_Select = 4'b0010; e.mem_r_addr_sel = 3'd1;
    applyStimulus(1'b1, 16'hB605, e, "sti_exec");
    e = dflt(16'hB605);
    e.state2_STI = 1'b1; e.RF_r_addr_0 = 3'd3; e.mem_wr_en = 1'b1;
    applyStimulus(1'b1, 16'hB605, e, "sti_exec2");

    // STR R5,R2,#5
    fetchDecode(16'h7A85, "str");
    e = dflt(16'h7A85);
    e.RF_r_addr_0 = 3'd2; e.add_const = 1'b1; e.SEXT_Select = 4'b0100; e.alu_sel = 2'd1;
    e.STR = 1'b1; e.RF_r_addr_1 = 3'd5; e.mem_wr_en = 1'b1;
    applyStimulus(1'b1, 16'h7A85, e, "str_exec");

    // ST R7,#1
    fetchDecode(16'h3E01, "st");
    e = dflt(16'h3E01);
    e.SEXT_Select = 4'b0010; e.RF_r_addr_0 = 3'd7; e.mem_wr_en = 1'b1;
    applyStimulus(1'b1, 16'h3E01, e, "st_exec");

    // Same ST, with reset asserted during its execute cycle
    fetchDecode(16'h3E01, "st_rst");
    applyStimulus(1'b0, 16'h3E01, initExp(16'h3E01), "st_rst_exec");
    applyStimulus(1'b1, 16'h3E01, initExp(16'h3E01), "st_rst_release");

    // RET
    fetchDecode(16'hC1C0, "ret");
    e = dflt(16'hC1C0);
    e.RF_r_addr_0 = 3'd7; e.JMP_RET_JSRR = 1'b1; e.pc_ld = 1'b1;
    applyStimulus(1'b1, 16'hC1C0, e, "ret_exec");

    // LEA R4,#-2
    fetchDecode(16'hE9FE, "lea");
    e = dflt(16'hE9FE);
    e.SEXT_Select = 4'b0010; e.RF_w_data_sel = 2'd3; e.RF_wr_addr = 3'd4; e.RF_wr_en = 1'b1;
    applyStimulus(1'b1, 16'hE9FE, e, "lea_exec");

    // LDR R6,R1,#-1
    fetchDecode(16'h6C7F, "ldr");
    e = dflt(16'h6C7F);
    e.RF_r_addr_0 = 3'd1; e.add_const = 1'b1; e.SEXT_Select = 4'b0100; e.alu_sel = 2'd1;
    e.mem_r_addr_sel = 3'd4; e.RF_w_data_sel = 2'd2; e.RF_wr_addr = 3'd6; e.RF_wr_en = 1'b1;
    applyStimulus(1'b1, 16'h6C7F, e, "ldr_exec");

    // NOT R4,R1
    fetchDecode(16'h987F, "not");
    e = dflt(16'h987F);
    e.RF_r_addr_0 = 3'd1; e.alu_sel = 2'd3; e.RF_wr_addr = 3'd4; e.RF_wr_en = 1'b1; e.cc_en = 1'b1;
    applyStimulus(1'b1, 16'h987F, e, "not_exec");

    // LD R5,#3
    fetchDecode(16'h2A03, "ld");
    e = dflt(16'h2A03);
    e.SEXT_Select = 4'b0010; e.mem_r_addr_sel = 3'd1; e.RF_w_data_sel = 2'd2;
    e.RF_wr_addr = 3'd5; e.RF_wr_en = 1'b1;
    applyStimulus(1'b1, 16'h2A03, e, "ld_exec");

    // RTI is a no-op
    fetchDecode(16'h8000, "rti");
    applyStimulus(1'b1, 16'h8000, dflt(16'h8000), "rti_exec");

    // HALT: the machine must stay idle with no fetches
    fetchDecode(16'hF025, "halt");
    applyStimulus(1'b1, 16'hF025, dflt(16'hF025), "halt_exec");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'hF025, dflt(16'hF025), "halt_idle");
    end

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/punc_controller.md
# punc_controller

Control unit for the PUnC LC3 processor; sits directly upstream of the datapath and drives every datapath control input from a fetch/decode/execute state machine and the instruction register (`ir`) the datapath returns. It sequences one LC3 instruction at a time: 3 cycles for most instructions, 4 for LDI/STI. It stops permanently on HALT.

## Interface
Parameters: none.
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  reset, asynchronous, active-low (asserted when 0)
- `ir`  input  16  instruction register contents from datapath
- `mem_wr_en`  output  1  memory write strobe
- `mem_r_addr_sel`  output  3  memory read address: 0 pc, 1 pc_adder, 2 indirect, 3 mem_r_data, 4 alu_c
- `state2_STI`  output  1  memory write address = indirect (STI second access)
- `STR`  output  1  STR mode: write data = RF_r_data_1, pc_adder = alu_c
- `RF_wr_addr`  output  3  register file write address
- `RF_wr_en`  output  1  register file write strobe
- `RF_r_addr_0`, `RF_r_addr_1`  output  3 each  register file read addresses
- `RF_w_data_sel`  output  2  RF write data: 0 alu_c, 1 pc, 2 mem_r_data, 3 pc_adder
- `ir_ld`  output  1  load IR from mem_r_data
- `JMP_RET_JSRR`  output  1  PC load source: 1 alu_c, 0 pc_adder
- `pc_ld`, `pc_clr`, `pc_up`  output  1 each  PC load / clear / increment
- `add_const`  output  1  ALU operand B = sign-extended constant
- `alu_sel`  output  2  ALU_FN_PASS/ADD/AND/NOT
- `cc_en`  output  1  update N/Z/P from alu_c
- `n`, `z`, `p`  output  1 each  branch condition mask
- `const`  output  11  always `ir[10:0]`
- `SEXT_Select`  output  4  one-hot: 1000 imm5, 0100 off6, 0010 off9, 0001 off11

## Operation
- States: INIT, FETCH, DECODE, EXECUTE, EXEC2, HALT.
- Transitions: INIT→FETCH, FETCH→DECODE, DECODE→EXECUTE. From EXECUTE: LDI/STI→EXEC2, HALT (1111)→HALT, all other opcodes→FETCH. EXEC2→FETCH. HALT→HALT.
- Defaults in every state: all strobes 0, all selects 0, n/z/p 0, `const` = `ir[10:0]`.
- INIT: `pc_clr`=1.
- FETCH: `mem_r_addr_sel`=0, `ir_ld`=1, `pc_up`=1.
- DECODE: defaults only.
- EXECUTE, per opcode. Common fields: DR/SR = `ir[11:9]`, BaseR/SR1 = `ir[8:6]`.
  - ADD/AND: `RF_r_addr_0`=SR1. If `ir[5]`: `add_const`=1, SEXT 1000; else `RF_r_addr_1`=`ir[2:0]`. `alu_sel` ADD or AND, `RF_w_data_sel`=0, `RF_wr_en`, `cc_en`.
  - NOT: `RF_r_addr_0`=SR1, `alu_sel` NOT, RF write of alu_c, `cc_en`.
  - BR: n,z,p = `ir[11:9]`, SEXT 0010. PC load is done by the datapath on a condition match; `pc_ld`=0.
  - LD: SEXT 0010, `mem_r_addr_sel`=1, `RF_w_data_sel`=2, `RF_wr_en`.
  - LDI: SEXT 0010, `mem_r_addr_sel`=1. The datapath captures the pointer into `indirect`.
  - EXEC2 for LDI: `mem_r_addr_sel`=2, `RF_w_data_sel`=2, `RF_wr_en`.
  - ST: SEXT 0010, `RF_r_addr_0`=SR, `alu_sel` PASS, `mem_wr_en`.
  - STI: execute cycle as LDI.
  - EXEC2 for STI: `state2_STI`=1, `RF_r_addr_0`=SR, `alu_sel` PASS, `mem_wr_en`.
  - LDR: `RF_r_addr_0`=BaseR, `add_const`, SEXT 0100, `alu_sel` ADD, `mem_r_addr_sel`=4, `RF_w_data_sel`=2, `RF_wr_en`.
  - STR: as LDR address generation, plus `STR`=1, `RF_r_addr_1`=SR, `mem_wr_en`.
  - JSR (`ir[11]`=1): SEXT 0001, `pc_ld`, `JMP_RET_JSRR`=0, `RF_wr_addr`=7, `RF_w_data_sel`=1, `RF_wr_en`.
  - JSRR: as JSR but `JMP_RET_JSRR`=1, `RF_r_addr_0`=BaseR, `alu_sel` PASS.
  - JMP/RET: `RF_r_addr_0`=BaseR, `alu_sel` PASS, `JMP_RET_JSRR`=1, `pc_ld`.
  - LEA: SEXT 0010, `RF_w_data_sel`=3, `RF_wr_en`. No cc update.
  - RTI (1000) and 1101: no-op.
- `cc_en` is asserted only for ADD/AND/NOT.

## Timing
- All outputs are combinational decode of the state register and `ir` (Moore on state, Mealy on `ir`).
- `rst`=0: state forced to INIT immediately; all outputs take INIT values in the same cycle, so no write strobe reaches the datapath.
- First FETCH occurs on the first edge after `rst` rises.
- JSRR R7: the read of R7 and the PC load use pre-edge values while R7 is written at the same edge. Required: pc = old R7.

## Structure
- Shared defines file holds the opcode constants, state encoding, mux-select constants, ALU_FN_* and SEXT one-hot codes.
- Natural sub-module: `punc_ctrl_decode`, a combinational map from (state, `ir`) to the control outputs. The state register and next-state logic stay in `punc_controller`.

## Test plan
All scenarios run with the datapath and memory attached.
- ADD: mem[0]=0x1261 (ADD R1,R1,#1), R1=5 → R1=6 after the edge ending cycle 3. pc=1. cc_en was high for exactly 1 cycle.
- BRz taken: Z=1, mem[1]=0x0402 → pc=4. With Z=0 → pc=2.
- LDI: mem[0]=0xA402, mem[3]=0x0010, mem[0x10]=0xBEEF → R2=0xBEEF. Exactly 4 cycles. ir_ld pulses once.
- JSR: mem[0]=0x4802 → R7=1, pc=3.
- HALT: mem[0]=0xF025 → state HALT. pc stays 1 for 20 cycles, no strobes.
- Reset mid-ST: drive `rst`=0 during EXECUTE of ST → mem_wr_en=0 the same cycle, memory unchanged. After release: INIT, pc=0.
